// File: rtl/uart_rcv_8n1.sv
// 8N1 UART receiver with rdy/clr_rdy byte handshake and framing/overrun flags.
// Define UART_RCV_PARITY_EN to receive 8E1 frames and drive parity_err.
module uart_rcv_8n1 #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       framing_err,
  output logic       overrun,
  output logic       parity_err
);

`ifdef UART_RCV_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam state_t AFTER_DATA = PARITY;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif

  localparam logic [15:0] HALF_BIT = 16'(BAUD_DIV / 2);
  localparam logic [15:0] FULL_BIT = 16'(BAUD_DIV - 1);

  state_t      state, next_state;
  logic        rx_m, rx_s, rx_q;
  logic [15:0] cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        tick;
  logic        load_half, load_full, start_frame, bit_clr, sample_data;
  logic        good_stop, bad_stop;
`ifdef UART_RCV_PARITY_EN
  logic        sample_par;
  logic        par_bit;
`endif

  assign tick = (cnt == 16'd0);

  // Preset to idle-high so reset release never looks like a start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_q <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
      rx_q <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    load_half   = 1'b0;
    load_full   = 1'b0;
    start_frame = 1'b0;
    bit_clr     = 1'b0;
    sample_data = 1'b0;
    good_stop   = 1'b0;
    bad_stop    = 1'b0;
`ifdef UART_RCV_PARITY_EN
    sample_par  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rx_q && !rx_s) begin
          next_state  = START;
          load_half   = 1'b1;
          start_frame = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (rx_s) begin
            next_state = IDLE;
          end else begin
            next_state = DATA;
            load_full  = 1'b1;
            bit_clr    = 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          sample_data = 1'b1;
          load_full   = 1'b1;
          if (bit_cnt == 3'd7) next_state = AFTER_DATA;
        end
      end
`ifdef UART_RCV_PARITY_EN
      PARITY: begin
        if (tick) begin
          sample_par = 1'b1;
          load_full  = 1'b1;
          next_state = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          next_state = IDLE;
          good_stop  = rx_s;
          bad_stop   = !rx_s;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 16'd0;
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
    end else begin
      if (load_half)      cnt <= HALF_BIT;
      else if (load_full) cnt <= FULL_BIT;
      else if (!tick)     cnt <= cnt - 16'd1;

      if (bit_clr)          bit_cnt <= 3'd0;
      else if (sample_data) bit_cnt <= bit_cnt + 3'd1;

      if (sample_data) shift <= {rx_s, shift[7:1]};
    end
  end

  // A completing frame takes priority over a same-cycle clr_rdy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= 8'h00;
      rdy         <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else if (good_stop) begin
      rx_data     <= shift;
      framing_err <= 1'b0;
      overrun     <= rdy;
      rdy         <= 1'b1;
    end else begin
      if (bad_stop)               framing_err <= 1'b1;
      if (start_frame || clr_rdy) rdy <= 1'b0;
      if (clr_rdy && rdy)         overrun <= 1'b0;
    end
  end

`ifdef UART_RCV_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (sample_par) par_bit    <= rx_s;
      if (good_stop)  parity_err <= ^{shift, par_bit};
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rcv_8n1.sv
// Randomized self-checking bench for uart_rcv_8n1 against a frame-level model.
module tb_uart_rcv_8n1;
  localparam int BAUD_DIV = 16;
`ifdef UART_RCV_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, RX, clr_rdy;
  logic [7:0] rx_data;
  logic       rdy, framing_err, overrun, parity_err;

  int checks   = 0;
  int failures = 0;
  int lat;

  logic [7:0] exp_data;
  logic       exp_rdy, exp_fe, exp_ov, exp_pe;

  uart_rcv_8n1 #(.BAUD_DIV(BAUD_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .clr_rdy(clr_rdy),
    .rx_data(rx_data), .rdy(rdy), .framing_err(framing_err),
    .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_rdy"},     32'(rdy),         32'(exp_rdy));
    checkOutput({tag, "_data"},    32'(rx_data),     32'(exp_data));
    checkOutput({tag, "_framing"}, 32'(framing_err), 32'(exp_fe));
    checkOutput({tag, "_overrun"}, 32'(overrun),     32'(exp_ov));
    checkOutput({tag, "_parity"},  32'(parity_err),  32'(exp_pe));
  endtask

  task automatic holdLine(input logic v, input int n);
    RX = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one whole frame; the model follows the frame-level rules
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    holdLine(1'b0, BAUD_DIV);
    exp_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      holdLine(b[i], BAUD_DIV);
      if (i == 3) checkAll("mid_frame");
    end
    if (PARITY_ON) holdLine(par_bit, BAUD_DIV);
    holdLine(stop_bit, BAUD_DIV);
    if (stop_bit) begin
      exp_ov   = exp_rdy;
      exp_rdy  = 1'b1;
      exp_data = b;
      exp_fe   = 1'b0;
      exp_pe   = PARITY_ON ? ^{b, par_bit} : 1'b0;
    end else begin
      exp_fe = 1'b1;
    end
    checkAll("frame_end");
  endtask

  task automatic clrPulse();
    clr_rdy = 1'b1;
    @(posedge clk);
    #1;
    clr_rdy = 1'b0;
    if (exp_rdy) begin
      exp_rdy = 1'b0;
      exp_ov  = 1'b0;
    end
    checkOutput("clr_rdy", 32'(rdy), 32'(exp_rdy));
    checkOutput("clr_overrun", 32'(overrun), 32'(exp_ov));
  endtask

  task automatic modelReset();
    exp_data = 8'h00;
    exp_rdy  = 1'b0;
    exp_fe   = 1'b0;
    exp_ov   = 1'b0;
    exp_pe   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] b;
    logic       stop_bit, par_bit;
    int         gap;

    RX      = 1'b1;
    clr_rdy = 1'b0;
    rst_n   = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkAll("reset");
    rst_n = 1'b1;
    holdLine(1'b1, 100);
    checkAll("idle");

    // First byte with latency measurement from the start edge
    fork
      applyStimulus(8'hA5, 1'b1, 1'b0);
      begin
        int cyc;
        cyc = 0;
        while (rdy !== 1'b1 && cyc < 400) begin
          @(posedge clk);
          #1;
          cyc++;
        end
        lat = cyc;
      end
    join
    if (PARITY_ON) checkOutput("latency_ok", 32'(lat >= 166 && lat <= 178), 32'd1);
    else           checkOutput("latency_ok", 32'(lat >= 150 && lat <= 162), 32'd1);
    clrPulse();

    // Zero-gap pair without consuming the first byte
    applyStimulus(8'h3C, 1'b1, ^8'h3C);
    applyStimulus(8'hC3, 1'b1, ^8'hC3);
    clrPulse();
    clrPulse();

    // Bad stop bit, then line held low with no edge
    applyStimulus(8'h55, 1'b0, ^8'h55);
    holdLine(1'b0, 40);
    checkAll("stuck_low");
    holdLine(1'b1, 20);
    applyStimulus(8'h96, 1'b1, ^8'h96);
    clrPulse();

    // Short low glitch aborts in START
    holdLine(1'b0, 4);
    holdLine(1'b1, 40);
    exp_rdy = 1'b0;
    checkAll("glitch");
    applyStimulus(8'h81, 1'b1, ^8'h81);

`ifdef UART_RCV_PARITY_EN
    applyStimulus(8'h07, 1'b1, 1'b1);
    applyStimulus(8'h07, 1'b1, 1'b0);
    clrPulse();
`endif

    // Reset in the middle of a frame
    holdLine(1'b0, BAUD_DIV);
    holdLine(1'b1, BAUD_DIV);
    holdLine(1'b0, 10);
    rst_n = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkAll("in_reset");
    RX    = 1'b1;
    rst_n = 1'b1;
    holdLine(1'b1, 20);
    checkAll("after_reset");
    applyStimulus(8'h5A, 1'b1, ^8'h5A);

    for (int n = 0; n < 10; n++) begin
      b        = 8'($urandom);
      stop_bit = ($urandom_range(0, 3) != 0);
      par_bit  = (^b) ^ ($urandom_range(0, 3) == 0);
      applyStimulus(b, stop_bit, par_bit);
      if (!stop_bit) holdLine(1'b1, 20);
      if ($urandom_range(0, 1) == 1) clrPulse();
      gap = $urandom_range(0, 20);
      if (gap > 0) holdLine(1'b1, gap);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
